// File: rtl/chaos_keystream_gen.sv
// Logistic-map keystream generator: iterates x' = 4x(1-x) in unsigned Q0.32 and streams
// each new state over valid/ready; any change of the PIO seed word reseeds the map.
`timescale 1ns/1ps

module chaos_keystream_gen #(
  parameter int unsigned WARMUP   = 16,
  parameter logic [31:0] SEED_FIX = 32'h2545_F491
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] shift_word,
  input  logic        enable,
  output logic [31:0] ks_data,
  output logic        ks_valid,
  input  logic        ks_ready,
  output logic [15:0] ks_count,
  output logic        seeded
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned HI_W   = 34;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned WARM_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_UPD  = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_x;
  logic [DATA_W-1:0]   r_shift_q;
  logic [WARM_W-1:0]   r_warm_cnt;
  logic [HI_W-1:0]     r_prod_hi;
  logic [DATA_W-1:0]   r_ks_data;
  logic                r_ks_valid;
  logic [CNT_W-1:0]    r_ks_count;
  logic                r_seeded;

  state_t              w_state_nxt;
  logic [DATA_W-1:0]   w_x_nxt;
  logic [WARM_W-1:0]   w_warm_nxt;
  logic [HI_W-1:0]     w_prod_nxt;
  logic [DATA_W-1:0]   w_ks_data_nxt;
  logic                w_ks_valid_nxt;
  logic [CNT_W-1:0]    w_ks_count_nxt;
  logic                w_seeded_nxt;

  logic                w_reseed;
  logic [DATA_W-1:0]   w_seed_val;
  logic [DATA_W-1:0]   w_neg_x;
  logic [HI_W-1:0]     w_prod_hi;
  logic [DATA_W-1:0]   w_map;

  assign w_reseed   = (shift_word != r_shift_q);
  assign w_seed_val = (shift_word == '0) ? SEED_FIX : shift_word;

  // Only product bits [63:30] feed the update: [63:62] flag saturation, [61:30] are nx.
  assign w_neg_x   = (~r_x) + DATA_W'(1);
  assign w_prod_hi = HI_W'((64'(r_x) * 64'(w_neg_x)) >> 30);

  always_comb begin
    w_map = r_prod_hi[DATA_W-1:0];
    if (r_prod_hi[HI_W-1:DATA_W] != 2'b00) begin
      w_map = 32'hFFFF_FFFF;
    end
    if (w_map == '0) begin
      w_map = SEED_FIX;
    end
  end

  // Next-state and registered-output logic; reseed overrides whatever the FSM decided.
  always_comb begin
    w_state_nxt    = r_state;
    w_x_nxt        = r_x;
    w_warm_nxt     = r_warm_cnt;
    w_prod_nxt     = r_prod_hi;
    w_ks_data_nxt  = r_ks_data;
    w_ks_valid_nxt = r_ks_valid;
    w_ks_count_nxt = r_ks_count;
    w_seeded_nxt   = r_seeded;

    case (r_state)
      ST_IDLE: begin
        if (enable && r_seeded) begin
          w_state_nxt = ST_MUL;
        end
      end
      ST_MUL: begin
        w_prod_nxt  = w_prod_hi;
        w_state_nxt = ST_UPD;
      end
      ST_UPD: begin
        w_x_nxt = w_map;
        if (r_warm_cnt != '0) begin
          w_warm_nxt  = r_warm_cnt - WARM_W'(1);
          w_state_nxt = ST_MUL;
        end else begin
          w_ks_data_nxt  = w_map;
          w_ks_valid_nxt = 1'b1;
          w_state_nxt    = ST_OUT;
        end
      end
      ST_OUT: begin
        if (r_ks_valid && ks_ready) begin
          w_ks_valid_nxt = 1'b0;
          w_ks_count_nxt = r_ks_count + CNT_W'(1);
          w_state_nxt    = enable ? ST_MUL : ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (w_reseed) begin
      w_x_nxt        = w_seed_val;
      w_warm_nxt     = WARM_W'(WARMUP);
      w_ks_count_nxt = '0;
      w_seeded_nxt   = 1'b1;
      w_state_nxt    = ST_IDLE;
      w_ks_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_x        <= '0;
      r_shift_q  <= '0;
      r_warm_cnt <= '0;
      r_prod_hi  <= '0;
      r_ks_data  <= '0;
      r_ks_valid <= 1'b0;
      r_ks_count <= '0;
      r_seeded   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_x        <= w_x_nxt;
      r_shift_q  <= shift_word;
      r_warm_cnt <= w_warm_nxt;
      r_prod_hi  <= w_prod_nxt;
      r_ks_data  <= w_ks_data_nxt;
      r_ks_valid <= w_ks_valid_nxt;
      r_ks_count <= w_ks_count_nxt;
      r_seeded   <= w_seeded_nxt;
    end
  end

  assign ks_data  = r_ks_data;
  assign ks_valid = r_ks_valid;
  assign ks_count = r_ks_count;
  assign seeded   = r_seeded;

endmodule

// File: tb/tb_chaos_keystream_gen.sv
// Scoreboard bench for chaos_keystream_gen: two instances (WARMUP=0 and WARMUP=1),
// directed stimulus pushes expected words, a negedge monitor checks every handshake.
`timescale 1ns/1ps

module tb_chaos_keystream_gen;

  localparam logic [31:0] SEED_FIX = 32'h2545_F491;

  typedef struct packed {
    logic [31:0] data;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;

  logic [31:0] sw0, d0;
  logic        en0, rdy0, v0, s0;
  logic [15:0] c0;
  logic [31:0] sw1, d1;
  logic        en1, rdy1, v1, s1;
  logic [15:0] c1;

  logic [31:0] sq0, sq1;
  exp_t        q0[$];
  exp_t        q1[$];
  exp_t        e0, e1;
  int unsigned hs_cyc0[$];
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] m1, m2;

  chaos_keystream_gen #(.WARMUP(0), .SEED_FIX(SEED_FIX)) dut0 (
    .clk(clk), .reset_n(reset_n), .shift_word(sw0), .enable(en0),
    .ks_data(d0), .ks_valid(v0), .ks_ready(rdy0), .ks_count(c0), .seeded(s0)
  );

  chaos_keystream_gen #(.WARMUP(1), .SEED_FIX(SEED_FIX)) dut1 (
    .clk(clk), .reset_n(reset_n), .shift_word(sw1), .enable(en1),
    .ks_data(d1), .ks_valid(v1), .ks_ready(rdy1), .ks_count(c1), .seeded(s1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Bench copy of the seed-change detector, so the monitor knows when a handshake is pre-empted.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sq0 <= '0;
      sq1 <= '0;
    end else begin
      sq0 <= sw0;
      sq1 <= sw1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] d, input logic [15:0] c);
    exp_t r;
    r.data = d;
    r.cnt  = c;
    return r;
  endfunction

  // Reference logistic map written directly from 4x(1-x) scaled to Q0.32.
  function automatic logic [31:0] lmap(input logic [31:0] x);
    logic [65:0] v;
    v = (66'd4 * 66'(x) * ((66'd1 << 32) - 66'(x))) >> 32;
    if (v > 66'h0_FFFF_FFFF) return 32'hFFFF_FFFF;
    if (v == 66'd0) return SEED_FIX;
    return v[31:0];
  endfunction

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (v0 && rdy0 && (sw0 == sq0)) begin
        hs_cyc0.push_back(cyc);
        if (q0.size() == 0) begin
          chk("dut0_unexpected_word", d0, 32'h0BAD_0BAD);
        end else begin
          e0 = q0.pop_front();
          chk("dut0_data", d0, e0.data);
          chk("dut0_count", 32'(c0), 32'(e0.cnt));
        end
      end
      if (v1 && rdy1 && (sw1 == sq1)) begin
        if (q1.size() == 0) begin
          chk("dut1_unexpected_word", d1, 32'h0BAD_0BAD);
        end else begin
          e1 = q1.pop_front();
          chk("dut1_data", d1, e1.data);
          chk("dut1_count", 32'(c1), 32'(e1.cnt));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for the monitor to consume all expected words, then stop accepting further words.
  task automatic drain(input int which, input string name);
    int k;
    k = 0;
    while (((which == 0) ? q0.size() : q1.size()) != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk(name, 32'((which == 0) ? q0.size() : q1.size()), 32'd0);
    if (which == 0) q0.delete(); else q1.delete();
    step();
    if (which == 0) rdy0 = 1'b0; else rdy1 = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    sw0 = '0; en0 = 1'b0; rdy0 = 1'b0;
    sw1 = '0; en1 = 1'b0; rdy1 = 1'b0;
    repeat (3) step();
    chk("rst_data", d0, 32'h0);
    chk("rst_valid", 32'(v0), 32'h0);
    chk("rst_count", 32'(c0), 32'h0);
    chk("rst_seeded", 32'(s0), 32'h0);
    reset_n = 1'b1;
    repeat (4) step();
    chk("zero_word_no_seed", 32'(s0), 32'h0);
    chk("zero_word_no_valid", 32'(v0), 32'h0);

    // Saturation at 2^31 during warm-up, then 3 and 0xB delivered.
    sw1 = 32'h8000_0000; en1 = 1'b1; rdy1 = 1'b1;
    q1.push_back(mk(32'h0000_0003, 16'd0));
    q1.push_back(mk(32'h0000_000B, 16'd1));
    drain(1, "sat_drain");
    chk("sat_seeded", 32'(s1), 32'h1);
    repeat (4) step();
    chk("sat_count", 32'(c1), 32'd2);

    // Fixed point 0xC000_0000 at full throughput.
    hs_cyc0.delete();
    sw0 = 32'h4000_0000; en0 = 1'b1; rdy0 = 1'b1;
    for (int i = 0; i < 3; i++) q0.push_back(mk(32'hC000_0000, 16'(i)));
    drain(0, "fix_drain");
    chk("fix_seeded", 32'(s0), 32'h1);
    chk("fix_hs_n", 32'(hs_cyc0.size()), 32'd3);
    if (hs_cyc0.size() >= 3) begin
      chk("fix_gap01", 32'(hs_cyc0[1] - hs_cyc0[0]), 32'd3);
      chk("fix_gap12", 32'(hs_cyc0[2] - hs_cyc0[1]), 32'd3);
    end
    repeat (4) step();
    chk("fix_count3", 32'(c0), 32'd3);

    // Backpressure: pending word held stable, then one single-cycle ready pulse.
    for (int i = 0; i < 10; i++) begin
      chk("bp_data", d0, 32'hC000_0000);
      chk("bp_valid", 32'(v0), 32'h1);
      chk("bp_count", 32'(c0), 32'd3);
      step();
    end
    q0.push_back(mk(32'hC000_0000, 16'd3));
    rdy0 = 1'b1;
    step();
    rdy0 = 1'b0;
    repeat (5) step();
    chk("bp_pulse_count", 32'(c0), 32'd4);
    chk("bp_next_valid", 32'(v0), 32'h1);

    // enable dropped in OUT: word still delivered, then idle.
    en0 = 1'b0;
    q0.push_back(mk(32'hC000_0000, 16'd4));
    rdy0 = 1'b1;
    repeat (8) step();
    chk("en_idle_valid", 32'(v0), 32'h0);
    chk("en_idle_count", 32'(c0), 32'd5);
    rdy0 = 1'b0;

    // Zero seed substitutes SEED_FIX.
    sw0 = 32'h0;
    step(); step();
    chk("zs_count_clr", 32'(c0), 32'd0);
    chk("zs_seeded", 32'(s0), 32'h1);
    chk("zs_valid", 32'(v0), 32'h0);
    m1 = lmap(SEED_FIX);
    m2 = lmap(m1);
    q0.push_back(mk(m1, 16'd0));
    q0.push_back(mk(m2, 16'd1));
    en0 = 1'b1; rdy0 = 1'b1;
    drain(0, "zs_drain");

    // Reseed in OUT with ready low, then again while in MUL.
    repeat (4) step();
    chk("rs_pending", 32'(v0), 32'h1);
    sw0 = 32'h1234_5678;
    step();
    chk("rs_valid_drop", 32'(v0), 32'h0);
    chk("rs_count_clr", 32'(c0), 32'd0);
    step();
    sw0 = 32'h0F0F_1234;
    m1 = lmap(32'h0F0F_1234);
    m2 = lmap(m1);
    q0.push_back(mk(m1, 16'd0));
    q0.push_back(mk(m2, 16'd1));
    rdy0 = 1'b1;
    drain(0, "rs_drain");

    // Asynchronous reset pulse while in UPD.
    repeat (4) step();
    sw0 = 32'h5555_AAAA;
    step(); step(); step();
    #2;
    reset_n = 1'b0;
    sw0 = 32'h0;
    sw1 = 32'h0;
    #0.5;
    chk("arst_data", d0, 32'h0);
    chk("arst_valid", 32'(v0), 32'h0);
    chk("arst_count", 32'(c0), 32'h0);
    chk("arst_seeded", 32'(s0), 32'h0);
    chk("arst_dut1_data", d1, 32'h0);
    #0.5;
    reset_n = 1'b1;
    en0 = 1'b1; rdy0 = 1'b1;
    repeat (10) step();
    chk("arst_stay_unseeded", 32'(s0), 32'h0);
    chk("arst_stay_invalid", 32'(v0), 32'h0);
    sw0 = 32'h3333_3333;
    q0.push_back(mk(lmap(32'h3333_3333), 16'd0));
    drain(0, "arst_drain");
    chk("arst_reseeded", 32'(s0), 32'h1);

    repeat (3) step();
    chk("end_q0_empty", 32'(q0.size()), 32'd0);
    chk("end_q1_empty", 32'(q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
